// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: round-robin arbiter sharing one serial tx framer between four requesters.
// Optional build macro NET_TX_ARB_PRIO_EN: channel 0 gets strict priority over channels 1-3.
module net_tx_arbiter #(
  parameter int IFG_CYCLES = 32,
  parameter int START_TMO  = 8,
  parameter int SEND_TMO   = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [7:0]   req_dest,
  input  logic [15:0]  req_len,
  input  logic [511:0] req_data,
  input  logic [1:0]   my_id,
  output logic [3:0]   gnt,
  output logic         done,
  output logic         done_err,
  output logic         tx_start,
  output logic [3:0]   tx_addr,
  output logic [3:0]   tx_len,
  output logic [127:0] tx_data,
  input  logic         tx_busy,
  output logic [2:0]   arb_state
);
  localparam int NUM_CH = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    SENDING   = 3'd4,
    REPORT    = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t       state, state_nxt;
  logic [15:0]  cnt;
  logic         err, err_nxt;
  logic [1:0]   ptr, gidx, win, idx;
  logic         win_vld;
  logic [1:0]   sel_dest;
  logic [3:0]   sel_len;
  logic [127:0] sel_data;

  // Descending scan so the closest channel after ptr is assigned last and wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = ptr + 2'(k);
`ifdef NET_TX_ARB_PRIO_EN
      if (req[idx] && idx != 2'd0) begin
        win     = idx;
        win_vld = 1'b1;
      end
`else
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
`endif
    end
`ifdef NET_TX_ARB_PRIO_EN
    if (req[0]) begin
      win     = 2'd0;
      win_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    sel_dest = '0;
    sel_len  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == 2'(i)) begin
        sel_dest = req_dest[2*i +: 2];
        sel_len  = req_len[4*i +: 4];
        sel_data = req_data[128*i +: 128];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    case (state)
      IDLE:      if (win_vld && !tx_busy) state_nxt = LOAD;
      LOAD: begin
        err_nxt   = (tx_len == 4'd0);
        state_nxt = (tx_len == 4'd0) ? REPORT : START;
      end
      // Holds off the pulse if the framer is somehow still busy.
      START:     if (!tx_busy) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) state_nxt = SENDING;
        else if (cnt == 16'(START_TMO - 1)) begin
          state_nxt = REPORT;
          err_nxt   = 1'b1;
        end
      end
      SENDING: begin
        if (!tx_busy) begin
          state_nxt = REPORT;
          err_nxt   = 1'b0;
        end else if (cnt == 16'(SEND_TMO - 1)) begin
          state_nxt = REPORT;
          err_nxt   = 1'b1;
        end
      end
      REPORT:    state_nxt = GAP;
      GAP:       if (cnt == 16'(IFG_CYCLES - 1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      err     <= 1'b0;
      ptr     <= 2'd3;
      gidx    <= '0;
      gnt     <= '0;
      tx_addr <= '0;
      tx_len  <= '0;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      // The tx_start cycle is the first cycle of the start-timeout window.
      if (state == IDLE || (state_nxt != state && !(state == START && state_nxt == WAIT_BUSY)))
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (state == IDLE && state_nxt == LOAD) begin
        gidx    <= win;
        gnt     <= 4'(1) << win;
        tx_addr <= {sel_dest, my_id};
        tx_len  <= sel_len;
        tx_data <= sel_data;
      end
      if (state == REPORT) begin
        gnt <= '0;
`ifdef NET_TX_ARB_PRIO_EN
        if (gidx != 2'd0) ptr <= gidx;
`else
        ptr <= gidx;
`endif
      end
    end
  end

  assign tx_start  = (state == START) && !tx_busy;
  assign done      = (state == REPORT);
  assign done_err  = (state == REPORT) && err;
  assign arb_state = state;
endmodule
